// File: rtl/delay_sched_pkg.sv
// Shared types, constants and gap arithmetic for the delay scheduler.
// DELAY_CTRL_VAL normally comes from udp_defines; the fallback below keeps
// this slice self-contained when that header is not part of the build.
// Optional feature macro: DELAY_SCHED_RAMP_EN (per-packet gap ramp).
`ifndef DELAY_CTRL_VAL
`define DELAY_CTRL_VAL 8'hFA
`endif

package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INSERT = 2'd1,
    PASS   = 2'd2
  } sched_state_t;

  localparam int GAP_WIDTH = 40;

  // Bit GAP_WIDTH-1 reads as a negative gap downstream, so never emit it.
  localparam logic [GAP_WIDTH-1:0] GAP_MAX = {1'b0, {(GAP_WIDTH-1){1'b1}}};

  // Any value that would look negative downstream is pinned to GAP_MAX.
  function automatic logic [GAP_WIDTH-1:0] gap_clamp(input logic [GAP_WIDTH-1:0] v);
    return v[GAP_WIDTH-1] ? GAP_MAX : v;
  endfunction

  // Add two gaps and saturate at GAP_MAX instead of wrapping.
  function automatic logic [GAP_WIDTH-1:0] gap_sat_add(input logic [GAP_WIDTH-1:0] a,
                                                       input logic [GAP_WIDTH-1:0] b);
    logic [GAP_WIDTH:0] sum;
    sum = {1'b0, gap_clamp(a)} + {1'b0, gap_clamp(b)};
    return (sum > {1'b0, GAP_MAX}) ? GAP_MAX : sum[GAP_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/delay_scheduler_if.sv
// Word-stream bus (data, ctrl, write strobe, ready) between pipeline stages.
// The master drives data/ctrl/wr and listens to rdy; the slave does the reverse.
interface delay_scheduler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/delay_gap_gen.sv
// Gap accumulator: produces gap_k for the header of packet k.
// gap_0 is always 0 so the first packet of a run departs immediately.
// With DELAY_SCHED_RAMP_EN the gap grows by a latched step per packet,
// otherwise it stays at the latched base and no adder is built.
module delay_gap_gen
  import delay_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 advance,
  input  logic [GAP_WIDTH-1:0] base,
`ifdef DELAY_SCHED_RAMP_EN
  input  logic [GAP_WIDTH-1:0] step,
`endif
  output logic [GAP_WIDTH-1:0] gap_k
);

  logic [GAP_WIDTH-1:0] gap_reg;
  logic [GAP_WIDTH-1:0] next_reg;

`ifdef DELAY_SCHED_RAMP_EN
  logic [GAP_WIDTH-1:0] step_reg;

  // Load clears the index; each advance moves to the next, saturated ramp value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_reg  <= '0;
      next_reg <= '0;
      step_reg <= '0;
    end else if (load) begin
      gap_reg  <= '0;
      next_reg <= gap_clamp(base);
      step_reg <= gap_clamp(step);
    end else if (advance) begin
      gap_reg  <= next_reg;
      next_reg <= gap_sat_add(next_reg, step_reg);
    end
  end
`else
  // Load clears the index; after the first advance the gap sticks at the base.
  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_reg  <= '0;
      next_reg <= '0;
    end else if (load) begin
      gap_reg  <= '0;
      next_reg <= gap_clamp(base);
    end else if (advance) begin
      gap_reg  <= next_reg;
    end
  end
`endif

  assign gap_k = gap_reg;

endmodule

// File: rtl/delay_scheduler.sv
// Packet-train sequencer ahead of the delay stage. Forwards packets unchanged,
// inserting one gap header word (ctrl = DELAY_CTRL_VAL) before each packet,
// and stops after num_pkts packets (0 = run until stopped).
// Optional feature macro: DELAY_SCHED_RAMP_EN adds gap_step and a gap ramp.
module delay_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int GAP_WIDTH  = 40,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  delay_scheduler_if.slave     in_bus,
  delay_scheduler_if.master    out_bus,
  input  logic                 sched_start,
  input  logic                 sched_stop,
  input  logic [GAP_WIDTH-1:0] gap_base,
`ifdef DELAY_SCHED_RAMP_EN
  input  logic [GAP_WIDTH-1:0] gap_step,
`endif
  input  logic [CNT_WIDTH-1:0] num_pkts,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  import delay_sched_pkg::*;

  sched_state_t state;
  sched_state_t state_next;

  logic [CNT_WIDTH-1:0]  num_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  count_inc;
  logic                  stop_pending;
  logic                  seen_payload;
  logic                  done_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CTRL_WIDTH-1:0] ctrl_reg;
  logic                  wr_reg;
  logic [GAP_WIDTH-1:0]  gap_k;

  logic in_rdy;
  logic accept;
  logic is_eop;
  logic emit_hdr;
  logic start_run;
  logic end_run;

  assign count_inc = count_reg + CNT_WIDTH'(1);
  assign accept    = (state == PASS) && in_bus.wr && out_bus.rdy;
  assign is_eop    = accept && (in_bus.ctrl != '0) && seen_payload;

  delay_gap_gen u_gap_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (start_run),
    .advance (is_eop),
    .base    (gap_base),
`ifdef DELAY_SCHED_RAMP_EN
    .step    (gap_step),
`endif
    .gap_k   (gap_k)
  );

  // Next-state and handshake decode; a stop in INSERT wins over emitting the header.
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    emit_hdr   = 1'b0;
    start_run  = 1'b0;
    end_run    = 1'b0;
    case (state)
      IDLE: begin
        if (sched_start) begin
          start_run  = 1'b1;
          state_next = INSERT;
        end
      end
      INSERT: begin
        if (sched_stop) begin
          end_run    = 1'b1;
          state_next = IDLE;
        end else if (out_bus.rdy) begin
          emit_hdr   = 1'b1;
          state_next = PASS;
        end
      end
      PASS: begin
        in_rdy = out_bus.rdy;
        if (is_eop) begin
          if (stop_pending || sched_stop ||
              ((num_reg != '0) && (count_inc == num_reg))) begin
            end_run    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = INSERT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Run bookkeeping: latched limit, packet counter, pending stop, EOP tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_reg      <= '0;
      count_reg    <= '0;
      stop_pending <= 1'b0;
      seen_payload <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= end_run;
      if (start_run) begin
        num_reg      <= num_pkts;
        count_reg    <= '0;
        stop_pending <= 1'b0;
      end else begin
        if (end_run)                          stop_pending <= 1'b0;
        else if (state == PASS && sched_stop) stop_pending <= 1'b1;
        if (is_eop) count_reg <= count_inc;
      end
      if (start_run || emit_hdr) seen_payload <= 1'b0;
      else if (accept)           seen_payload <= (in_bus.ctrl == '0);
    end
  end

  // Registered output: either the gap header or a copy of the accepted word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg <= '0;
      ctrl_reg <= '0;
      wr_reg   <= 1'b0;
    end else begin
      wr_reg <= emit_hdr || accept;
      if (emit_hdr) begin
        data_reg <= DATA_WIDTH'(gap_k);
        ctrl_reg <= CTRL_WIDTH'(`DELAY_CTRL_VAL);
      end else if (accept) begin
        data_reg <= in_bus.data;
        ctrl_reg <= in_bus.ctrl;
      end
    end
  end

  assign in_bus.rdy   = in_rdy;
  assign out_bus.data = data_reg;
  assign out_bus.ctrl = ctrl_reg;
  assign out_bus.wr   = wr_reg;
  assign busy         = (state != IDLE);
  assign done         = done_reg;
  assign pkt_count    = count_reg;

endmodule

// File: doc/delay_scheduler.md
# delay_scheduler

Packet-train sequencer placed directly upstream of the `delay` stage.
- Accepts packets from the packet store and forwards them unchanged.
- Before each packet, inserts one module-header word with ctrl = `DELAY_CTRL_VAL`. That word carries the inter-departure gap the delay stage must enforce.
- Counts transmitted packets, stops after a programmed number, and reports status to the register block.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- GAP_WIDTH, 40, gap width in PTP counter units; matches the delay stage.
- CNT_WIDTH, 32, packet counter width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low.
- in_data  in  DATA_WIDTH  upstream word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl.
- in_wr  in  1  upstream write strobe; legal only while in_rdy is high.
- in_rdy  out  1  may accept a word.
- out_data  out  DATA_WIDTH  registered output word.
- out_ctrl  out  CTRL_WIDTH  registered output ctrl.
- out_wr  out  1  registered write strobe.
- out_rdy  in  1  downstream almost-full-style ready; one write after deassertion is tolerated.
- sched_start  in  1  single-cycle start pulse.
- sched_stop  in  1  single-cycle stop pulse.
- gap_base  in  GAP_WIDTH  gap applied to packets 1..N-1.
- gap_step  in  GAP_WIDTH  per-packet gap increment; present only with `DELAY_SCHED_RAMP_EN`.
- num_pkts  in  CNT_WIDTH  packets per run; 0 = unlimited.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run ends.
- pkt_count  out  CNT_WIDTH  packets completed in the current or last run.

## Operation
Packet framing:
- Header words have ctrl != 0; payload words have ctrl == 0.
- EOP is the first word with ctrl != 0 that follows a ctrl == 0 word.

States:
- IDLE: in_rdy=0, out_wr=0.
  - sched_start latches gap_base, gap_step and num_pkts; clears pkt_count and the gap index k; goes to INSERT.
- INSERT: in_rdy=0.
  - When out_rdy=1, emit one word: ctrl=`DELAY_CTRL_VAL`, data={zeros, gap_k}; then go to PASS.
  - gap_0 = 0, so the first packet departs immediately.
- PASS: in_rdy=out_rdy; every accepted input word is copied to the output registers.
  - On the EOP word: pkt_count++, k++.
  - Then, in priority order:
    - stop pending → IDLE with done;
    - num_pkts != 0 and pkt_count == num_pkts → IDLE with done;
    - otherwise → INSERT.

Gap arithmetic:
- gap_k = gap_base for k ≥ 1.
- The result saturates at 2^(GAP_WIDTH-1)-1 (40'h7F_FFFF_FFFF), because bit 39 is treated as negative downstream.
- A programmed gap_base with bit 39 set is clamped to the same value.

Stop and start handling:
- sched_stop in INSERT → IDLE immediately with done; no header is left dangling.
- sched_stop in PASS → sets stop pending; the current packet completes first.
- sched_stop in IDLE is ignored.
- sched_start while busy is ignored.
- Simultaneous start and stop in IDLE → start wins; the stop is discarded.

Counter wrap:
- Unlimited mode: pkt_count wraps 2^32-1 → 0 without ending the run.

busy:
- busy = (state != IDLE).

## Timing
Reset values (reset=0 at a clk edge):
- State IDLE; out_data=0, out_ctrl=0, out_wr=0, in_rdy=0.
- busy=0, done=0, pkt_count=0, stop pending cleared.
- Reset mid-packet truncates the packet, so downstream must be reset together with this block.

Latencies:
- sched_start in cycle N → INSERT in N+1 → header out_wr=1 in N+2 if out_rdy was 1 in N+1.
- Forwarding latency is 1 cycle: out_wr(t+1) = in_wr(t).
- Following an EOP accepted in cycle t, the next packet's header appears no earlier than t+2; in_rdy stays low for at least one cycle (the INSERT cycle).
- done pulses in the cycle after the final EOP is accepted, together with busy falling.

Handshake:
- out_rdy low in INSERT stalls the header.
- No words are dropped or duplicated under any out_rdy pattern.

## Configuration
- `DELAY_SCHED_RAMP_EN` defined:
  - gap_step port exists.
  - gap_k = gap_base + (k-1)·gap_step for k ≥ 1, computed by accumulation with the same saturation.
- `DELAY_SCHED_RAMP_EN` undefined:
  - No gap_step port.
  - Constant gap_base for k ≥ 1; no adder logic.

## Structure
- Package delay_sched_pkg holds:
  - state enum (IDLE, INSERT, PASS);
  - GAP_WIDTH;
  - GAP_MAX = 2^(GAP_WIDTH-1)-1;
  - the saturating-add function.
- `DELAY_CTRL_VAL` comes from udp_defines.
- Sub-module delay_gap_gen provides the gap accumulator:
  - inputs: load, advance, base, step;
  - output: gap_k, with saturation.

## Test plan
- num_pkts=3, gap_base=1000, three 8-word packets, out_rdy=1 → output has 3 inserted words with data 0, 1000, 1000; packets are byte-exact; pkt_count=3; one done pulse.
- Toggle out_rdy every cycle during the same run → output identical to the out_rdy=1 case; in_wr never occurs while in_rdy=0.
- num_pkts=0, assert sched_stop mid-payload of packet 5 → packet 5 completes; no 6th header is emitted; pkt_count=5; done asserted.
- gap_base=40'h80_0000_0000 → inserted data 40'h7F_FFFF_FFFF. With the ramp enabled: gap_base=40'h7F_FFFF_FFF0 and gap_step=16 → packet 2 carries 40'h7F_FFFF_FFFF.
- reset driven low mid-packet, then a new sched_start → out_wr=0 and pkt_count=0 after reset; the next run begins with gap 0.
- sched_start while busy, and start and stop in the same cycle in IDLE → configuration is not relatched while busy; the simultaneous case starts a run.
